column_prefetch_buffer: RTL and testbench
=========================================

# column_prefetch_buffer

Double-buffered column store between the texture ROM and `neopixel_controller`. When the angular index `theta` changes, the block prefetches one full texture column, all `LED_COUNT` pixels, from the synchronous ROM into a back bank. It swaps banks only on a strip-frame boundary, so a WS2812 frame never mixes two columns. It serves `pixel` against the controller's `next_px_num` with the same 1-cycle latency as a direct ROM read.

## Interface
- `LED_COUNT`, 52: pixels per column / strip length
- `TEX_WIDTH`, 256: texture columns per revolution
- `THETA_BITS`, 6: width of `theta`
- `PX_BITS`, 6: width of `next_px_num`
- `DATA_WIDTH`, 24: pixel colour width
- `ADDR_WIDTH`, 14: ROM address width, ≥ clog2(LED_COUNT*TEX_WIDTH)

Ports:
- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `theta`  in  THETA_BITS  current angle index, synchronous to `clk`
- `rom_addr`  out  ADDR_WIDTH  texture ROM address
- `rom_data`  in  DATA_WIDTH  ROM output, valid 1 cycle after address
- `next_px_num`  in  PX_BITS  LED index requested by the strip controller
- `pixel`  out  DATA_WIDTH  colour for `next_px_num`, registered
- `busy`  out  1  high while state is FILL or DRAIN
- `drop_count`  out  8  restarted-fill counter (see Configuration)

## Operation
- Column: `col = (theta * TEX_WIDTH) >> THETA_BITS`, full-width product, truncated to clog2(TEX_WIDTH) bits.
- Address for fill index i: `(LED_COUNT-1-i)*TEX_WIDTH + col` (row flip).
- Two banks of LED_COUNT × DATA_WIDTH. `rd_bank` is read; `!rd_bank` is written.
- FSM states:
  - IDLE: if `!col_valid` or `col != last_col`, latch `col` into `last_col`, set `col_valid`, idx←0, go to FILL.
  - FILL: drive `rom_addr` for idx, then idx++. Write `rom_data` to entry idx-1 when idx>0. After idx=LED_COUNT-1 is issued, go to DRAIN.
  - DRAIN: write entry LED_COUNT-1, go to READY.
  - READY: a pending full column exists. On a frame boundary, toggle `rd_bank`, set `shown`, go to IDLE. Otherwise, if `col != last_col`, relatch, restart FILL at idx 0 in the same write bank, and count a drop. The newest column wins.
- `theta` changes during FILL/DRAIN are ignored until the fill completes. They are then caught in READY.
- Frame boundary: `next_px_num == 0` while the registered previous `next_px_num != 0`.
- A boundary while not in READY is skipped: the current bank is shown for one more frame.
- `pixel` register:
  - 0 when `!shown`;
  - 0 when `next_px_num >= LED_COUNT`;
  - else `bank[rd_bank][next_px_num]`.
- `rom_addr` holds the last driven value outside FILL.

## Timing
- Reset values:
  - state IDLE;
  - `rd_bank` 0;
  - `col_valid` 0;
  - `shown` 0;
  - `pixel` 0;
  - `rom_addr` 0;
  - `busy` 0;
  - `drop_count` 0.
- Bank contents are not reset.
- Change detected in IDLE at cycle T:
  - FILL covers T+1..T+LED_COUNT (idx 0..LED_COUNT-1);
  - DRAIN is T+LED_COUNT+1;
  - READY is from T+LED_COUNT+2.
- Swap takes effect on the clock edge after the boundary cycle.
- `pixel` for a `next_px_num` presented in cycle k is valid in cycle k+1.
- Boundary coinciding with the DRAIN cycle: no swap (READY is not yet entered); wait for the next boundary.
- Boundary and `theta` change in the same READY cycle: the swap has priority; the change is handled in IDLE next cycle.
- Reset asserted mid-FILL: immediate return to reset values; output blanked until a new fill is swapped in.

## Configuration
- `COL_BUF_STATS_EN` defined: `drop_count` is an 8-bit saturating counter (sticks at 255). It increments on each READY-state refill restart.
- `COL_BUF_STATS_EN` undefined: `drop_count` is tied to 0 and no counter is synthesised.

## Test plan
- Reset, then `theta`=0 and `next_px_num` cycling 0..51:
  - `pixel`=0 until the first boundary after READY;
  - afterwards `pixel[i]` equals ROM entry (51-i)*256.
- `theta`=1 → 2 with the ROM model holding address-unique data:
  - `busy` is high for exactly 53 cycles;
  - `rom_addr` sequence is 51*256+4 down to 0*256+4, step -256, then the same for col 8.
- `theta` change while the controller is mid-frame (`next_px_num`=20):
  - no `pixel` change until `next_px_num` wraps to 0;
  - whole frame 0..51 comes from one column.
- Two `theta` changes while READY, with no boundary:
  - with `COL_BUF_STATS_EN`, `drop_count`=2;
  - displayed column is the last `theta` only.
- `next_px_num`=52 and 63 → `pixel`=0.
- Assert `reset` at FILL idx 30 → all outputs 0 next cycle; recovery as in the first scenario.

Source files
------------

// File: rtl/column_prefetch_buffer_if.sv
// rtl/column_prefetch_buffer_if.sv - bus bundle between the column buffer, texture ROM and strip controller
//
// Signals:
//   theta       angle index from the rotation tracker
//   rom_addr    texture ROM address driven by the buffer
//   rom_data    texture ROM output, one cycle after rom_addr
//   next_px_num LED index requested by the strip controller
//   pixel       registered colour for next_px_num
//   busy        column fill in progress
//   drop_count  number of fills restarted before being shown
// Modports: master = column buffer side, slave = ROM / controller side.
interface column_prefetch_buffer_if #(
    parameter int THETA_BITS = 6,
    parameter int PX_BITS    = 6,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 14
);
    logic [THETA_BITS-1:0] theta;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [PX_BITS-1:0]    next_px_num;
    logic [DATA_WIDTH-1:0] pixel;
    logic                  busy;
    logic [7:0]            drop_count;

    modport master (
        input  theta, rom_data, next_px_num,
        output rom_addr, pixel, busy, drop_count
    );

    modport slave (
        output theta, rom_data, next_px_num,
        input  rom_addr, pixel, busy, drop_count
    );
endinterface

// File: rtl/column_prefetch_buffer.sv
// rtl/column_prefetch_buffer.sv - double-buffered texture column store feeding the LED strip controller
//
// Prefetches one texture column (LED_COUNT pixels, row-flipped) from a synchronous
// ROM into the back bank whenever theta selects a new column, and swaps banks only
// on a strip-frame boundary so a frame never mixes two columns.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    column_prefetch_buffer_if.master (theta, rom_addr/rom_data, next_px_num,
//          pixel, busy, drop_count)
// Optional build macro: COL_BUF_STATS_EN enables the saturating drop_count counter;
// without it drop_count is tied to 0.
module column_prefetch_buffer #(
    parameter int LED_COUNT  = 52,
    parameter int TEX_WIDTH  = 256,
    parameter int THETA_BITS = 6,
    parameter int PX_BITS    = 6,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    column_prefetch_buffer_if.master    bus
);
    localparam int COL_W  = $clog2(TEX_WIDTH);
    localparam int IDX_W  = $clog2(LED_COUNT);
    localparam int PROD_W = THETA_BITS + COL_W + 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, READY} state_t;

    state_t                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [COL_W-1:0]      last_col_q;
    logic                  col_valid_q;
    logic                  rd_bank_q, rd_bank_d;
    logic                  shown_q, shown_d;
    logic                  busy_q;
    logic [PX_BITS-1:0]    prev_px_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
    logic [DATA_WIDTH-1:0] bank_q [2][LED_COUNT];

    logic [PROD_W-1:0]     prod;
    logic [COL_W-1:0]      col;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  col_change;
    logic                  boundary;
    logic                  swap;
    logic                  restart;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;

    assign prod = PROD_W'(bus.theta) * PROD_W'(TEX_WIDTH);
    assign col  = COL_W'(prod >> THETA_BITS);

    // Row flip: fill index 0 fetches the bottom texture row.
    assign fill_addr = ADDR_WIDTH'((LED_COUNT - 1 - int'(idx_q)) * TEX_WIDTH + int'(col));

    assign col_change = !col_valid_q || (col != last_col_q);
    assign boundary   = (bus.next_px_num == '0) && (prev_px_q != '0);
    assign swap       = (state_q == READY) && boundary;
    assign restart    = (state_q == READY) && !boundary && col_change;

    assign rd_bank_d = rd_bank_q ^ swap;
    assign shown_d   = shown_q | swap;

    // The ROM answers one cycle late, so entry idx-1 lands while idx is addressed;
    // DRAIN catches the last entry.
    assign wr_en  = ((state_q == FILL) && (idx_q != '0)) || (state_q == DRAIN);
    assign wr_idx = (state_q == DRAIN) ? IDX_W'(LED_COUNT - 1) : idx_q - IDX_W'(1);

    // Read through the post-swap bank so pixel 0 of the boundary request already
    // comes from the new column.
    always_comb begin
        pixel_d = '0;
        if (shown_d && (32'(bus.next_px_num) < LED_COUNT)) begin
            pixel_d = bank_q[rd_bank_d][IDX_W'(bus.next_px_num)];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank_q[~rd_bank_q][wr_idx] <= bus.rom_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_col_q  <= '0;
            col_valid_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            shown_q     <= 1'b0;
            busy_q      <= 1'b0;
            prev_px_q   <= '0;
            rom_addr_q  <= '0;
            pixel_q     <= '0;
        end else begin
            prev_px_q <= bus.next_px_num;
            rd_bank_q <= rd_bank_d;
            shown_q   <= shown_d;
            pixel_q   <= pixel_d;
            if (state_q == FILL) begin
                rom_addr_q <= fill_addr;
            end
            case (state_q)
                IDLE: begin
                    if (col_change) begin
                        last_col_q  <= col;
                        col_valid_q <= 1'b1;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                FILL: begin
                    if (idx_q == IDX_W'(LED_COUNT - 1)) begin
                        state_q <= DRAIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DRAIN: begin
                    busy_q  <= 1'b0;
                    state_q <= READY;
                end
                READY: begin
                    if (swap) begin
                        state_q <= IDLE;
                    end else if (restart) begin
                        // Newest column wins: refill the same back bank from scratch.
                        last_col_q <= col;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= FILL;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rom_addr = (state_q == FILL) ? fill_addr : rom_addr_q;
    assign bus.pixel    = pixel_q;
    assign bus.busy     = busy_q;

`ifdef COL_BUF_STATS_EN
    logic [7:0] drop_count_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= '0;
        end else if (restart && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end
    assign bus.drop_count = drop_count_q;
`else
    assign bus.drop_count = 8'd0;
`endif
endmodule

// File: tb/tb_column_prefetch_buffer.sv
// tb/tb_column_prefetch_buffer.sv - directed self-checking bench for column_prefetch_buffer
module tb_column_prefetch_buffer;
    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 256;
    localparam int THETA_BITS = 6;
    localparam int PX_BITS    = 6;
    localparam int DATA_WIDTH = 24;
    localparam int ADDR_WIDTH = 14;
`ifdef COL_BUF_STATS_EN
    localparam int DROP_EXP = 2;
`else
    localparam int DROP_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    column_prefetch_buffer_if #(
        .THETA_BITS(THETA_BITS), .PX_BITS(PX_BITS),
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    column_prefetch_buffer #(
        .LED_COUNT(LED_COUNT), .TEX_WIDTH(TEX_WIDTH), .THETA_BITS(THETA_BITS),
        .PX_BITS(PX_BITS), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] rom_f(input logic [ADDR_WIDTH-1:0] a);
        return {10'h2A5, a};
    endfunction

    always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for one fill, checking its length and the row-flipped address walk.
    task automatic measure_fill(input string tag, input int col);
        int cnt = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (bus.busy) begin
                cnt++;
                check({tag, "_addr"}, 32'(bus.rom_addr),
                      32'(((cnt <= 52) ? (52 - cnt) : 0) * TEX_WIDTH + col));
            end else if (cnt > 0) begin
                break;
            end
        end
        check({tag, "_busy_len"}, 32'(cnt), 32'd53);
    endtask

    task automatic run_frame(input string tag, input int col, input bit blank);
        for (int i = 0; i < LED_COUNT; i++) begin
            bus.next_px_num = PX_BITS'(i);
            step();
            check(tag, 32'(bus.pixel),
                  blank ? 32'd0 : 32'(rom_f(ADDR_WIDTH'((51 - i) * TEX_WIDTH + col))));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.theta = '0;
        bus.next_px_num = '0;
        step();
        step();
        check("rst_pixel", 32'(bus.pixel), 32'd0);
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_drop", 32'(bus.drop_count), 32'd0);
        reset = 1'b0;

        // First column after reset: blank until the first boundary in READY.
        measure_fill("fill_c0", 0);
        run_frame("blank_c0", 0, 1'b1);
        run_frame("frame_c0", 0, 1'b0);

        // theta 1 -> col 4, then theta 2 -> col 8.
        bus.theta = 6'd1;
        measure_fill("fill_c4", 4);
        run_frame("frame_c4", 4, 1'b0);
        bus.theta = 6'd2;
        measure_fill("fill_c8", 8);
        run_frame("frame_c8", 8, 1'b0);

        // Change while the controller is mid-frame: current frame and the next
        // (boundary lands during the fill) stay on col 8.
        for (int i = 0; i < LED_COUNT; i++) begin
            bus.next_px_num = PX_BITS'(i);
            if (i == 20) bus.theta = 6'd3;
            step();
            check("mid_c8", 32'(bus.pixel), 32'(rom_f(ADDR_WIDTH'((51 - i) * TEX_WIDTH + 8))));
        end
        run_frame("hold_c8", 8, 1'b0);
        run_frame("frame_c12", 12, 1'b0);

        // Two changes while READY with no boundary: newest column wins.
        bus.theta = 6'd4;
        measure_fill("fill_c16", 16);
        bus.theta = 6'd5;
        measure_fill("fill_c20", 20);
        bus.theta = 6'd6;
        measure_fill("fill_c24", 24);
        check("drop_count", 32'(bus.drop_count), 32'(DROP_EXP));
        run_frame("frame_c24", 24, 1'b0);

        // Out-of-range LED indices.
        bus.next_px_num = 6'd52;
        step();
        check("px52", 32'(bus.pixel), 32'd0);
        bus.next_px_num = 6'd63;
        step();
        check("px63", 32'(bus.pixel), 32'd0);

        // Reset in the middle of a fill at idx 30.
        bus.next_px_num = '0;
        bus.theta = 6'd7;
        step();
        check("c28_idx0_addr", 32'(bus.rom_addr), 32'(51 * TEX_WIDTH + 28));
        check("c28_pix_before", 32'(bus.pixel), 32'(rom_f(ADDR_WIDTH'(51 * TEX_WIDTH + 24))));
        repeat (30) step();
        check("c28_idx30_addr", 32'(bus.rom_addr), 32'(21 * TEX_WIDTH + 28));
        reset = 1'b1;
        step();
        check("mid_rst_pixel", 32'(bus.pixel), 32'd0);
        check("mid_rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
        reset = 1'b0;
        measure_fill("fill_c28", 28);
        run_frame("blank_c28", 28, 1'b1);
        run_frame("frame_c28", 28, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
